tone_step_sequencer: RTL

- Self-clocked successor to the fixed 16-note demonstrate-mode tone table.
- Owns its beat timing, a writable per-step note/pan memory, a per-step enable mask, and loop or one-shot playback.
- Emits 32-bit toneL/toneR frequency words straight into the existing PWM/speaker path; one instance per voice.

---
 rtl/tone_step_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/tone_step_sequencer.sv
// Per-voice step sequencer: beat timing, writable note/pan memory, step mask,
// loop or one-shot playback, driving 32-bit left/right frequency words.
module tone_step_sequencer #(
    parameter int unsigned STEPS          = 16,
    parameter int unsigned BEATS_PER_STEP = 4,
    parameter int unsigned TICK_DIV       = 25000000,
    parameter int unsigned SIL            = 50000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       start,
    input  logic                       loop,
    input  logic [STEPS-1:0]           step_mask,
    input  logic                       wr_en,
    input  logic [$clog2(STEPS)-1:0]   wr_addr,
    input  logic [5:0]                 wr_data,
    output logic [31:0]                toneL,
    output logic [31:0]                toneR,
    output logic [$clog2(STEPS)-1:0]   step_idx,
    output logic                       playing,
    output logic                       done
);

    localparam int unsigned AW = $clog2(STEPS);
    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned BW = (BEATS_PER_STEP > 1) ? $clog2(BEATS_PER_STEP) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS_PER_STEP - 1);
    localparam logic [AW-1:0] STEP_LAST = AW'(STEPS - 1);
    localparam logic [31:0]   SIL_W     = 32'(SIL);

    typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;

    state_t         state;
    logic [TW-1:0]  tick_cnt;
    logic [BW-1:0]  beat_cnt;
    logic [5:0]     mem [STEPS];

    logic [5:0]     cur_entry;
    logic           cur_on;
    logic [31:0]    cur_freq;

    // Note code to frequency word; codes 0 and 15 are silent.
    function automatic logic [31:0] freq(input logic [3:0] code);
        case (code)
            4'd1:    freq = 32'd262;
            4'd2:    freq = 32'd294;
            4'd3:    freq = 32'd330;
            4'd4:    freq = 32'd349;
            4'd5:    freq = 32'd392;
            4'd6:    freq = 32'd440;
            4'd7:    freq = 32'd494;
            4'd8:    freq = 32'd524;
            4'd9:    freq = 32'd588;
            4'd10:   freq = 32'd660;
            4'd11:   freq = 32'd698;
            4'd12:   freq = 32'd784;
            4'd13:   freq = 32'd880;
            4'd14:   freq = 32'd988;
            default: freq = SIL_W;
        endcase
    endfunction

    assign cur_entry = mem[step_idx];
    assign cur_on    = step_mask[step_idx];
    assign cur_freq  = freq(cur_entry[3:0]);

    // Note/pan memory; reset restores the ascending default scale on both channels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < STEPS; i++) begin
                mem[i] <= {2'b11, 4'((i % 14) + 1)};
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Playback FSM with beat/step counters and registered tone outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            beat_cnt <= '0;
            step_idx <= '0;
            toneL    <= SIL_W;
            toneR    <= SIL_W;
            playing  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;

            if (state != IDLE && en) begin
                toneL <= (cur_entry[5] && cur_on) ? cur_freq : SIL_W;
                toneR <= (cur_entry[4] && cur_on) ? cur_freq : SIL_W;
            end else begin
                toneL <= SIL_W;
                toneR <= SIL_W;
            end

            if (start) begin
                state    <= PLAY;
                tick_cnt <= '0;
                beat_cnt <= '0;
                step_idx <= '0;
                playing  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        playing <= 1'b0;
                    end
                    PLAY, PAUSE: begin
                        if (!en) begin
                            state <= PAUSE;
                        end else begin
                            state <= PLAY;
                            if (tick_cnt != TICK_LAST) begin
                                tick_cnt <= tick_cnt + TW'(1);
                            end else begin
                                tick_cnt <= '0;
                                if (beat_cnt != BEAT_LAST) begin
                                    beat_cnt <= beat_cnt + BW'(1);
                                end else begin
                                    beat_cnt <= '0;
                                    if (step_idx != STEP_LAST) begin
                                        step_idx <= step_idx + AW'(1);
                                    end else if (loop) begin
                                        step_idx <= '0;
                                    end else begin
                                        // One-shot end: hold on the last step.
                                        state   <= IDLE;
                                        playing <= 1'b0;
                                        done    <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        playing <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
